// File: rtl/mac_pkg.sv
// Shared types and sizing helpers for the multiply-accumulate engine.
// Imported by the accumulator top and used by the saturate stage downstream.
package mac_pkg;

  typedef enum logic {
    ACCUM  = 1'b0,
    OUTPUT = 1'b1
  } state_e;

  // Accumulator width: full product plus guard MSBs.
  function automatic int acc_width(int bw, int guard);
    return 2 * bw + guard;
  endfunction

  // Width able to hold a term count from 0 up to max_len.
  function automatic int cnt_width(int max_len);
    return $clog2(max_len + 1);
  endfunction

  localparam int DEF_BIT_WIDTH = 16;
  localparam int DEF_PROD_W    = 2 * DEF_BIT_WIDTH;

  localparam logic [DEF_PROD_W-1:0] PROD_MAX =
    {1'b0, {(DEF_PROD_W-1){1'b1}}};
  localparam logic [DEF_PROD_W-1:0] PROD_MIN =
    {1'b1, {(DEF_PROD_W-1){1'b0}}};

endpackage

// File: rtl/mac_accumulator_acc_clamp.sv
// Clamps a guard-extended accumulator to the signed output range.
// Same rule as the saturate stage, so both narrowings agree.
module acc_clamp #(
  parameter int IN_W  = 36,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  acc_i,
  output logic [OUT_W-1:0] acc_o,
  output logic             clip_o
);

  // Bits above the output sign must all copy the sign to be in range.
  logic [IN_W-OUT_W:0] top;
  logic                in_range;

  assign top      = acc_i[IN_W-1:OUT_W-1];
  assign in_range = (&top) | ~(|top);

  // Pick truncated value, or the signed max/min on overflow.
  always_comb begin
    acc_o  = acc_i[OUT_W-1:0];
    clip_o = 1'b0;
    if (!in_range) begin
      clip_o = 1'b1;
      if (acc_i[IN_W-1]) begin
        acc_o = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
        acc_o = {1'b0, {(OUT_W-1){1'b1}}};
      end
    end
  end

endmodule

// File: rtl/mac_accumulator.sv
// Streaming signed MAC: sums a*b terms until last or MAX_LEN,
// then presents the clamped full-precision result on valid/ready.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int BIT_WIDTH = 16,
  parameter int ACC_GUARD = 4,
  parameter int MAX_LEN   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [BIT_WIDTH-1:0]           in_a,
  input  logic [BIT_WIDTH-1:0]           in_b,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [2*BIT_WIDTH-1:0]         out_acc,
  output logic                           out_clip,
  output logic                           out_err,
  output logic [$clog2(MAX_LEN+1)-1:0]   out_len
);

  localparam int PROD_W = 2 * BIT_WIDTH;
  localparam int ACC_W  = acc_width(BIT_WIDTH, ACC_GUARD);
  localparam int CNT_W  = cnt_width(MAX_LEN);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_LEN - 1);

  state_e             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [PROD_W-1:0]  out_acc_q;
  logic               out_clip_q;
  logic               out_err_q;
  logic [CNT_W-1:0]   out_len_q;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic [ACC_W-1:0]         acc_base;
  logic [CNT_W-1:0]         cnt_base;
  logic [ACC_W-1:0]         acc_d;
  logic [CNT_W-1:0]         cnt_d;
  logic                     term_done;
  logic                     in_xfer;
  logic                     out_xfer;
  logic [PROD_W-1:0]        clamp_acc;
  logic                     clamp_clip;

  // Both operands sign-extended first, so the low PROD_W bits
  // are the exact signed product.
  assign prod     = PROD_W'($signed(in_a)) * PROD_W'($signed(in_b));
  assign prod_ext = ACC_W'(prod);

  // A pair taken while a result is leaving starts a fresh sum.
  assign acc_base  = (state_q == OUTPUT) ? '0 : acc_q;
  assign cnt_base  = (state_q == OUTPUT) ? '0 : cnt_q;
  assign acc_d     = acc_base + prod_ext;
  assign cnt_d     = cnt_base + CNT_W'(1);
  assign term_done = in_last | (cnt_base == LAST_CNT);

  assign in_ready  = (state_q == ACCUM) | out_ready;
  assign out_valid = (state_q == OUTPUT);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  assign out_acc  = out_acc_q;
  assign out_clip = out_clip_q;
  assign out_err  = out_err_q;
  assign out_len  = out_len_q;

  acc_clamp #(
    .IN_W  (ACC_W),
    .OUT_W (PROD_W)
  ) u_clamp (
    .acc_i  (acc_d),
    .acc_o  (clamp_acc),
    .clip_o (clamp_clip)
  );

  // Accumulate terms; on the final term latch the result and hand off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      cnt_q      <= '0;
      out_acc_q  <= '0;
      out_clip_q <= 1'b0;
      out_err_q  <= 1'b0;
      out_len_q  <= '0;
    end else if (in_xfer) begin
      if (term_done) begin
        out_acc_q  <= clamp_acc;
        out_clip_q <= clamp_clip;
        out_err_q  <= ~in_last;
        out_len_q  <= cnt_d;
        acc_q      <= '0;
        cnt_q      <= '0;
        state_q    <= OUTPUT;
      end else begin
        acc_q      <= acc_d;
        cnt_q      <= cnt_d;
        state_q    <= ACCUM;
      end
    end else if (out_xfer) begin
      state_q <= ACCUM;
    end
  end

endmodule
